drain_encoder: RTL and testbench

//   Sequential N-to-log2(N) encoder; the inverse of the team's 2-to-4 decoder.

---
 rtl/drain_encoder.sv | 122 ++++++++++++
 tb/tb_drain_encoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/drain_encoder.sv
// drain_encoder
//   Sequential N-to-log2(N) encoder. Captures a multi-hot request vector and
//   hands out the index of every set bit, lowest index first. Each index is
//   delivered on one code_valid/code_ready handshake.
//
//   State | Meaning
//   ------+------------------------------------------------------------
//   IDLE  | no vector held; may capture one when enabled
//   DRAIN | pending holds the bits not yet transferred (never zero here)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (overrides everything)
//   Enable      block enable; 0 freezes state and pending bits
//   req_valid   req_in is presented
//   req_in      request vector, bit i = request i
//   req_ready   block can capture a vector
//   code_valid  code_out holds a valid index
//   code_ready  consumer accepts code_out
//   code_out    index of lowest pending bit (0 when nothing is pending)
//   code_last   code_out is the last pending index of the vector
//   err_empty   one-cycle pulse after an all-zero vector was offered
//
// N must be a power of two (>= 2) and W must equal log2(N).

module drain_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Enable,
    input  logic         req_valid,
    input  logic [N-1:0] req_in,
    output logic         req_ready,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [W-1:0] code_out,
    output logic         code_last,
    output logic         err_empty
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           err_empty_q, err_empty_d;

    logic [W-1:0]   low_idx;
    logic [N-1:0]   pend_minus_one;
    logic [N-1:0]   pending_rest;
    logic           one_left;

    // Priority search from the top down so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = W'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; if nothing remains, exactly one
    // bit was set.
    assign pend_minus_one = pending_q - {{(N-1){1'b0}}, 1'b1};
    assign pending_rest   = pending_q & pend_minus_one;
    assign one_left       = (pending_q != '0) && (pending_rest == '0);

    assign req_ready  = Enable && (state_q == ST_IDLE);
    assign code_valid = Enable && (state_q == ST_DRAIN);
    assign code_out   = low_idx;
    assign code_last  = code_valid && one_left;
    // Gated so a pulse never shows while the block is disabled.
    assign err_empty  = err_empty_q && Enable;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        err_empty_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_in != '0) begin
                        pending_d = req_in;
                        state_d   = ST_DRAIN;
                    end else begin
                        err_empty_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (code_valid && code_ready) begin
                    pending_d = pending_rest;
                    if (one_left) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            err_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            err_empty_q <= err_empty_d;
        end
    end

endmodule

// File: tb/tb_drain_encoder.sv
// tb_drain_encoder
//   Bench for drain_encoder (N=4). The reference keeps the not-yet-delivered
//   indices of the captured vector as an ascending queue; outputs are
//   predicted from that queue and compared every cycle.

module tb_drain_encoder;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         req_valid;
    logic [N-1:0] req_in;
    logic         req_ready;
    logic         code_valid;
    logic         code_ready;
    logic [W-1:0] code_out;
    logic         code_last;
    logic         err_empty;

    int n_checks;
    int n_errors;

    // reference state
    int pq[$];
    bit err_m;

    // transfer log for directed sequences
    int xfer_codes[$];
    int xfer_last[$];

    drain_encoder #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Enable     (enable),
        .req_valid  (req_valid),
        .req_in     (req_in),
        .req_ready  (req_ready),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_out   (code_out),
        .code_last  (code_last),
        .err_empty  (err_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: drive inputs, advance reference at the edge, then compare
    // all outputs on the following falling edge.
    task automatic cycle(input bit r, input bit en, input bit rv, input logic [N-1:0] rin, input bit cr);
        bit hs_code;
        rst        = r;
        enable     = en;
        req_valid  = rv;
        req_in     = rin;
        code_ready = cr;
        @(posedge clk);
        // record what was transferred on this edge (DUT outputs still pre-edge)
        hs_code = !r && en && (pq.size() != 0) && cr;
        if (hs_code) begin
            xfer_codes.push_back(pq[0]);
            xfer_last.push_back(pq.size() == 1 ? 1 : 0);
        end
        if (r) begin
            pq.delete();
            err_m = 1'b0;
        end else if (!en) begin
            err_m = 1'b0;
        end else if (pq.size() == 0) begin
            err_m = 1'b0;
            if (rv) begin
                if (rin == '0) begin
                    err_m = 1'b1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (rin[i]) pq.push_back(i);
                    end
                end
            end
        end else begin
            err_m = 1'b0;
            if (cr) void'(pq.pop_front());
        end
        @(negedge clk);
        check_eq("req_ready",  32'(req_ready),  32'(en && pq.size() == 0));
        check_eq("code_valid", 32'(code_valid), 32'(en && pq.size() != 0));
        check_eq("code_out",   32'(code_out),   32'(pq.size() != 0 ? pq[0] : 0));
        check_eq("code_last",  32'(code_last),  32'(en && pq.size() == 1));
        check_eq("err_empty",  32'(err_empty),  32'(en && err_m));
    endtask

    initial begin
        int err_pulses;
        n_checks = 0;
        n_errors = 0;
        err_m    = 1'b0;

        // 1. reset for two cycles
        cycle(1, 1, 0, 4'b0000, 0);
        cycle(1, 1, 0, 4'b0000, 0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_code_out", 32'(code_out), 32'd0);

        // 2. single bit
        xfer_codes.delete(); xfer_last.delete();
        cycle(0, 1, 1, 4'b0001, 1);
        check_eq("t2_valid_after_capture", 32'(code_valid), 32'd1);
        cycle(0, 1, 0, 4'b0000, 1);
        check_eq("t2_ready_again", 32'(req_ready), 32'd1);
        check_eq("t2_xfers", 32'(xfer_codes.size()), 32'd1);
        if (xfer_codes.size() == 1) begin
            check_eq("t2_code", 32'(xfer_codes[0]), 32'd0);
            check_eq("t2_last", 32'(xfer_last[0]), 32'd1);
        end

        // 3. two bits, back to back
        xfer_codes.delete(); xfer_last.delete();
        cycle(0, 1, 1, 4'b1010, 1);
        cycle(0, 1, 0, 4'b0000, 1);
        cycle(0, 1, 0, 4'b0000, 1);
        check_eq("t3_xfers", 32'(xfer_codes.size()), 32'd2);
        if (xfer_codes.size() == 2) begin
            check_eq("t3_code0", 32'(xfer_codes[0]), 32'd1);
            check_eq("t3_last0", 32'(xfer_last[0]), 32'd0);
            check_eq("t3_code1", 32'(xfer_codes[1]), 32'd3);
            check_eq("t3_last1", 32'(xfer_last[1]), 32'd1);
        end

        // 4. all bits, alternating backpressure
        xfer_codes.delete(); xfer_last.delete();
        cycle(0, 1, 1, 4'b1111, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 4'b0000, (i % 2) == 0);
        check_eq("t4_xfers", 32'(xfer_codes.size()), 32'd4);
        for (int i = 0; i < xfer_codes.size(); i++) check_eq("t4_order", 32'(xfer_codes[i]), 32'(i));

        // 5. zero vector
        err_pulses = 0;
        cycle(0, 1, 1, 4'b0000, 1);
        if (err_empty) err_pulses++;
        check_eq("t5_no_valid", 32'(code_valid), 32'd0);
        cycle(0, 1, 0, 4'b0000, 1);
        if (err_empty) err_pulses++;
        cycle(0, 1, 0, 4'b0000, 1);
        if (err_empty) err_pulses++;
        check_eq("t5_pulse_count", 32'(err_pulses), 32'd1);

        // 6. disable mid-drain, then reset
        xfer_codes.delete(); xfer_last.delete();
        cycle(0, 1, 1, 4'b1110, 1);
        cycle(0, 1, 0, 4'b0000, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'b0000, 1);
        cycle(1, 1, 0, 4'b0000, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'b0000, 1);
        check_eq("t6_xfers", 32'(xfer_codes.size()), 32'd1);
        check_eq("t6_ready", 32'(req_ready), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 1) == 1),
                  N'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
